// File: rtl/axis_debug_pkg.sv
// Shared definitions for the AXI-Stream debug blocks: popcount sizing,
// the "no packet seen" minimum value and a width-aware saturating adder.
package axis_debug_pkg;

    localparam logic [63:0] MIN_RESET = '1;

    function automatic int popcount_width(input int bw);
        return $clog2(bw + 1);
    endfunction

    // Adds two values held in the low 'width' bits; returns {overflow, result}.
    // On overflow the result holds at all-ones (saturate) or wraps modulo 2^width.
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width,
                                            input logic        saturate);
        logic [63:0] mask;
        logic [64:0] sum;
        logic        ovf;
        logic [63:0] res;
        mask = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        sum  = {1'b0, a} + {1'b0, b};
        ovf  = (sum > {1'b0, mask});
        if (ovf) res = saturate ? mask : (sum[63:0] & mask);
        else     res = sum[63:0];
        return {ovf, res};
    endfunction

endpackage

// File: rtl/axis_strb_popcount.sv
// Counts the asserted strobe bits of one AXI-Stream beat (bytes carried).
module axis_strb_popcount
    import axis_debug_pkg::*;
#(
    parameter int C_AXIS_BYTEWIDTH = 4
) (
    input  logic [C_AXIS_BYTEWIDTH-1:0]                        strb,
    output logic [popcount_width(C_AXIS_BYTEWIDTH)-1:0]        count
);

    localparam int PCW = popcount_width(C_AXIS_BYTEWIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < C_AXIS_BYTEWIDTH; i++) begin
            count = count + PCW'(strb[i]);
        end
    end

endmodule

// File: rtl/axis_stream_monitor.sv
// Inline AXI-Stream monitor: wires the stream straight through and gathers
// byte/beat/packet/stall counts and min/max packet length with snapshot bank.
module axis_stream_monitor
    import axis_debug_pkg::*;
#(
    parameter int C_AXIS_BYTEWIDTH = 4,
    parameter int C_COUNT_WIDTH    = 32,
    parameter int C_SATURATE       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          input_s_axis_tvalid,
    input  logic [8*C_AXIS_BYTEWIDTH-1:0] input_s_axis_tdata,
    input  logic [C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tstrb,
    input  logic                          input_s_axis_tlast,
    output logic                          input_s_axis_tready,
    output logic                          output_m_axis_tvalid,
    output logic [8*C_AXIS_BYTEWIDTH-1:0] output_m_axis_tdata,
    output logic [C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tstrb,
    output logic                          output_m_axis_tlast,
    input  logic                          output_m_axis_tready,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          snapshot,
    output logic [C_COUNT_WIDTH-1:0]      byte_count,
    output logic [C_COUNT_WIDTH-1:0]      beat_count,
    output logic [C_COUNT_WIDTH-1:0]      packet_count,
    output logic [C_COUNT_WIDTH-1:0]      stall_count,
    output logic [C_COUNT_WIDTH-1:0]      max_packet_bytes,
    output logic [C_COUNT_WIDTH-1:0]      min_packet_bytes,
    output logic                          overflow,
    output logic                          snapshot_done
);

    localparam int                       CW    = C_COUNT_WIDTH;
    localparam int                       PCW   = popcount_width(C_AXIS_BYTEWIDTH);
    localparam logic                     SAT   = (C_SATURATE != 0);
    localparam logic [C_COUNT_WIDTH-1:0] MIN_W = MIN_RESET[C_COUNT_WIDTH-1:0];

    // Handshake: a beat moves when tvalid & tready are both high at a rising
    // edge; the monitor never drives either, so the producer sees the
    // consumer's tready unchanged and a stall is tvalid held with tready low.
    assign output_m_axis_tvalid = input_s_axis_tvalid;
    assign output_m_axis_tdata  = input_s_axis_tdata;
    assign output_m_axis_tstrb  = input_s_axis_tstrb;
    assign output_m_axis_tlast  = input_s_axis_tlast;
    assign input_s_axis_tready  = output_m_axis_tready;

    logic           xfer;
    logic           stall;
    logic [PCW-1:0] nbytes;
    logic [63:0]    nb64;

    assign xfer  = input_s_axis_tvalid &  output_m_axis_tready;
    assign stall = input_s_axis_tvalid & ~output_m_axis_tready;

    axis_strb_popcount #(
        .C_AXIS_BYTEWIDTH(C_AXIS_BYTEWIDTH)
    ) u_popcount (
        .strb  (input_s_axis_tstrb),
        .count (nbytes)
    );

    assign nb64 = 64'(nbytes);

    logic [CW-1:0] live_bytes, live_beats, live_packets, live_stalls;
    logic [CW-1:0] live_max, live_min, pkt_len;
    logic          live_ovf;

    logic [64:0]   sum_beat, sum_byte, sum_pkt, sum_stall, sum_len;
    logic [CW-1:0] cur_len;
    logic          ovf_now;
    logic          unused_bits;

    assign sum_beat  = sat_add(64'(live_beats),   64'd1, CW, SAT);
    assign sum_byte  = sat_add(64'(live_bytes),   nb64,  CW, SAT);
    assign sum_pkt   = sat_add(64'(live_packets), 64'd1, CW, SAT);
    assign sum_stall = sat_add(64'(live_stalls),  64'd1, CW, SAT);
    assign sum_len   = sat_add(64'(pkt_len),      nb64,  CW, SAT);
    assign cur_len   = sum_len[CW-1:0];

    assign ovf_now = (xfer & (sum_beat[64] | sum_byte[64]))
                   | (xfer & input_s_axis_tlast & sum_pkt[64])
                   | (stall & sum_stall[64]);

    assign unused_bits = ^{sum_beat, sum_byte, sum_pkt, sum_stall, sum_len};

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_len          <= '0;
            live_bytes       <= '0;
            live_beats       <= '0;
            live_packets     <= '0;
            live_stalls      <= '0;
            live_max         <= '0;
            live_min         <= MIN_W;
            live_ovf         <= 1'b0;
            byte_count       <= '0;
            beat_count       <= '0;
            packet_count     <= '0;
            stall_count      <= '0;
            max_packet_bytes <= '0;
            min_packet_bytes <= MIN_W;
            overflow         <= 1'b0;
            snapshot_done    <= 1'b0;
        end else begin
            // Packet length keeps tracking through enable/clear so a packet
            // already in flight is still measured in full.
            if (xfer) pkt_len <= input_s_axis_tlast ? '0 : cur_len;

            snapshot_done <= snapshot;
            if (snapshot) begin
                byte_count       <= live_bytes;
                beat_count       <= live_beats;
                packet_count     <= live_packets;
                stall_count      <= live_stalls;
                max_packet_bytes <= live_max;
                min_packet_bytes <= live_min;
                overflow         <= live_ovf;
            end

            if (clear) begin
                live_bytes   <= '0;
                live_beats   <= '0;
                live_packets <= '0;
                live_stalls  <= '0;
                live_max     <= '0;
                live_min     <= MIN_W;
                live_ovf     <= 1'b0;
            end else if (enable) begin
                if (xfer) begin
                    live_beats <= sum_beat[CW-1:0];
                    live_bytes <= sum_byte[CW-1:0];
                    if (input_s_axis_tlast) begin
                        live_packets <= sum_pkt[CW-1:0];
                        if (cur_len > live_max) live_max <= cur_len;
                        if (cur_len < live_min) live_min <= cur_len;
                    end
                end
                if (stall) live_stalls <= sum_stall[CW-1:0];
                live_ovf <= live_ovf | ovf_now;
            end
        end
    end

endmodule
